// File: rtl/maskmul_pipe.sv
// Two-stage first-order masked AND/XOR with a fresh output mask.
// Partial products are registered before recombination; valid/ready on both sides.
module maskmul_pipe #(
    parameter int WIDTH   = 2,
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op_sel,
    input  logic [WIDTH-1:0]   am,
    input  logic [WIDTH-1:0]   bm,
    input  logic [WIDTH-1:0]   ma,
    input  logic [WIDTH-1:0]   mb,
    input  logic [WIDTH-1:0]   mq,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   qm,
    output logic [COUNT_W-1:0] done_count
);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
        logic [WIDTH-1:0] w;
    } terms_t;

    terms_t s1_terms;
    terms_t s1_next;
    logic   s1_valid;
    logic   s2_valid;
    logic   s2_adv;
    logic   s1_adv;
    logic   in_xfer;
    logic   out_xfer;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_xfer  = s2_valid && out_ready;

    // The fresh mask enters only the x term, before any share recombination.
    always_comb begin
        s1_next = '0;
        unique case (op_sel)
            1'b0: begin
                s1_next.x = (am & bm) ^ mq;
                s1_next.y = am & mb;
                s1_next.z = ma & bm;
                s1_next.w = ma & mb;
            end
            1'b1: begin
                s1_next.x = am ^ mq;
                s1_next.y = bm;
                s1_next.z = ma;
                s1_next.w = mb;
            end
            default: s1_next = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_terms <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_terms <= s1_next;
            end
        end
    end

    // Fixed recombination order keeps the share mixing sequence deterministic.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            qm       <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                qm <= ((s1_terms.x ^ s1_terms.y) ^ s1_terms.z) ^ s1_terms.w;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_count <= '0;
        end else if (out_xfer) begin
            done_count <= done_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_maskmul_pipe.sv
// Directed table, handshake corner cases and a random scoreboard run
// for maskmul_pipe at WIDTH=8, COUNT_W=3.
module tb_maskmul_pipe;

    localparam int W  = 8;
    localparam int CW = 3;

    typedef struct {
        logic         op;
        logic [W-1:0] am;
        logic [W-1:0] bm;
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        logic [W-1:0] mq;
        logic [W-1:0] qm;
    } vec_t;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] mq;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          op_sel = 1'b0;
    logic [W-1:0]  am = '0;
    logic [W-1:0]  bm = '0;
    logic [W-1:0]  ma = '0;
    logic [W-1:0]  mb = '0;
    logic [W-1:0]  mq = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  qm;
    logic [CW-1:0] done_count;

    int   checks = 0;
    int   errors = 0;
    int   cons = 0;
    int   got = 0;
    vec_t tbl[8];
    vec_t pend[$];
    exp_t expq[$];

    maskmul_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op_sel(op_sel),
        .am(am),
        .bm(bm),
        .ma(ma),
        .mb(mb),
        .mq(mq),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .qm(qm),
        .done_count(done_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive(input vec_t v);
        op_sel = v.op;
        am = v.am;
        bm = v.bm;
        ma = v.ma;
        mb = v.mb;
        mq = v.mq;
    endtask

    function automatic logic [W-1:0] model(input vec_t v);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = v.am ^ v.ma;
        b = v.bm ^ v.mb;
        return v.op ? (a ^ b) : (a & b);
    endfunction

    // Each cycle: drive, let in_ready settle, then log transfers for the next edge.
    task automatic stream(input int max_cyc, input bit rnd, input bit rdy);
        exp_t e;
        for (int c = 0; c < max_cyc; c++) begin
            if (pend.size() == 0 && expq.size() == 0) break;
            out_ready = rnd ? ($urandom_range(0, 9) < 7) : rdy;
            if (pend.size() > 0 && (!rnd || $urandom_range(0, 9) < 7)) begin
                drive(pend[0]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("stream_unmasked", 32'(qm ^ e.mq), 32'(e.r));
                end
                cons++;
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back('{model(pend[0]), pend[0].mq});
                void'(pend.pop_front());
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int seq[3];
        int seen;
        vec_t v;

        tbl[0] = '{1'b0, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h00};
        tbl[1] = '{1'b1, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
        tbl[2] = '{1'b0, 8'hF0, 8'h0F, 8'h0F, 8'hF0, 8'hAA, 8'h55};
        tbl[3] = '{1'b1, 8'h3C, 8'h5A, 8'h00, 8'h00, 8'hFF, 8'h99};
        tbl[4] = '{1'b0, 8'hA5, 8'h12, 8'h5A, 8'h00, 8'h0F, 8'h1D};
        tbl[5] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h00, 8'h00, 8'h7E};
        tbl[6] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hC3, 8'hC3};
        tbl[7] = '{1'b1, 8'hFF, 8'h0F, 8'h0F, 8'hFF, 8'h5A, 8'h5A};

        step();
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_qm", 32'(qm), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Isolated vectors: exact two-cycle latency and hand-computed qm.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            in_valid = 1'b1;
            #1;
            check("tbl_in_ready", 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            check("tbl_lat1_idle", 32'(out_valid), 32'd0);
            step();
            check("tbl_lat2_valid", 32'(out_valid), 32'd1);
            check("tbl_qm", 32'(qm), 32'(tbl[i].qm));
            cons++;
            step();
            check("tbl_drained", 32'(out_valid), 32'd0);
        end
        check("tbl_count", 32'(done_count), 32'(cons % (1 << CW)));

        // Back-to-back AND/XOR/AND, one result per cycle.
        seq = '{0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_qm", 32'(qm), 32'(tbl[seq[i-2]].qm));
                cons++;
            end
            if (i < 3) begin
                drive(tbl[seq[i]]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        check("b2b_empty", 32'(out_valid), 32'd0);

        // Backpressure: two accepts then stall, then drain in order.
        for (int i = 2; i < 6; i++) pend.push_back(tbl[i]);
        got = 0;
        stream(4, 1'b0, 1'b0);
        #1;
        check("bp_accepted", 32'(expq.size()), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_qm", 32'(qm), 32'(tbl[2].qm));
        step();
        check("bp_qm_hold", 32'(qm), 32'(tbl[2].qm));
        stream(30, 1'b0, 1'b1);
        check("bp_drained", 32'(pend.size() + expq.size()), 32'd0);
        check("bp_got", 32'(got), 32'd4);
        check("bp_count", 32'(done_count), 32'(cons % (1 << CW)));

        // Reset with both stages full and a transfer offered on both sides.
        pend.push_back(tbl[6]);
        pend.push_back(tbl[7]);
        stream(3, 1'b0, 1'b0);
        check("pre_rst_full", 32'(out_valid), 32'd1);
        reset = 1'b1;
        out_ready = 1'b1;
        drive(tbl[0]);
        in_valid = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_qm", 32'(qm), 32'd0);
        check("midrst_count", 32'(done_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        pend.delete();
        expq.delete();
        cons = 0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);

        // Nine results through a 3-bit counter wraps to 1.
        for (int i = 0; i < 9; i++) pend.push_back(tbl[i % 8]);
        stream(60, 1'b0, 1'b1);
        check("wrap_drained", 32'(pend.size() + expq.size()), 32'd0);
        check("wrap_count", 32'(done_count), 32'd1);

        // Random traffic on both handshakes.
        for (int i = 0; i < 1000; i++) begin
            v.op = 1'($urandom);
            v.am = 8'($urandom);
            v.bm = 8'($urandom);
            v.ma = 8'($urandom);
            v.mb = 8'($urandom);
            v.mq = 8'($urandom);
            v.qm = '0;
            pend.push_back(v);
        end
        stream(20000, 1'b1, 1'b0);
        check("rand_drained", 32'(pend.size() + expq.size()), 32'd0);
        check("rand_count", 32'(done_count), 32'(cons % (1 << CW)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
